// File: rtl/axi_ram_read_beat_gen.sv
// rtl/axi_ram_read_beat_gen.sv - AXI read-channel beat generator: burst address sequencing, RAM reads, 2-deep beat buffer
// One RAM read per beat is issued only when the buffer is guaranteed room, so backpressure never drops a beat.
module axi_ram_read_beat_gen #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 32,
   parameter int LEN_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [LEN_WIDTH-1:0]  cmd_len,
   input  logic [1:0]            cmd_burst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   output logic                  mem_en,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic [DATA_WIDTH-1:0] u_data,
   output logic                  u_valid,
   output logic                  u_last,
   input  logic                  u_ready
);
   localparam int STEP_SHIFT = $clog2(DATA_WIDTH / 8);
   localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(DATA_WIDTH / 8);
   localparam logic [1:0] MODE_FIXED = 2'd0;
   localparam logic [1:0] MODE_INCR  = 2'd1;
   localparam logic [1:0] MODE_WRAP  = 2'd2;

   typedef enum logic {IDLE, ISSUE} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH-1:0] wrap_mask_q, wrap_mask_d;
   logic [1:0]            mode_q, mode_d;
   logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
   logic                  inflight_q, inflight_d;
   logic                  inflight_last_q, inflight_last_d;
   logic [DATA_WIDTH-1:0] buf_data_q [2];
   logic [DATA_WIDTH-1:0] buf_data_d [2];
   logic                  buf_last_q [2];
   logic                  buf_last_d [2];
   logic                  wr_ptr_q, wr_ptr_d;
   logic                  rd_ptr_q, rd_ptr_d;
   logic [1:0]            count_q, count_d;

   logic                  wrap_legal;
   logic                  pop;
   logic                  issue;
   logic [2:0]            occupancy;
   logic [ADDR_WIDTH-1:0] incr_addr;
   logic [ADDR_WIDTH-1:0] next_addr;

   always_comb begin
      pop       = (count_q != 2'd0) && u_ready;
      // Entries that will be held after this edge if nothing new is issued.
      occupancy = 3'(count_q) + 3'(inflight_q) - 3'(pop);
      issue     = (state_q == ISSUE) && (occupancy < 3'd2) && !rst;
      cmd_ready = (state_q == IDLE) && !rst;

      wrap_legal = (cmd_len == LEN_WIDTH'(1)) || (cmd_len == LEN_WIDTH'(3)) ||
                   (cmd_len == LEN_WIDTH'(7)) || (cmd_len == LEN_WIDTH'(15));

      incr_addr = addr_q + STEP;
      case (mode_q)
         MODE_FIXED: next_addr = addr_q;
         MODE_WRAP:  next_addr = (addr_q & ~wrap_mask_q) | (incr_addr & wrap_mask_q);
         default:    next_addr = incr_addr;
      endcase
   end

   always_comb begin
      state_d         = state_q;
      addr_d          = addr_q;
      wrap_mask_d     = wrap_mask_q;
      mode_d          = mode_q;
      remaining_d     = remaining_q;
      buf_data_d      = buf_data_q;
      buf_last_d      = buf_last_q;
      wr_ptr_d        = wr_ptr_q;
      rd_ptr_d        = rd_ptr_q;
      inflight_d      = issue;
      inflight_last_d = issue && (remaining_q == '0);

      if (cmd_valid && cmd_ready) begin
         addr_d      = cmd_addr;
         remaining_d = cmd_len;
         wrap_mask_d = ((ADDR_WIDTH'(cmd_len) + ADDR_WIDTH'(1)) << STEP_SHIFT) - ADDR_WIDTH'(1);
         state_d     = ISSUE;
         if (cmd_burst == MODE_FIXED)
            mode_d = MODE_FIXED;
         else if (cmd_burst == MODE_WRAP && wrap_legal)
            mode_d = MODE_WRAP;
         else
            mode_d = MODE_INCR;
      end

      if (issue) begin
         remaining_d = remaining_q - LEN_WIDTH'(1);
         addr_d      = next_addr;
         if (remaining_q == '0)
            state_d = IDLE;
      end

      // RAM data is valid the cycle after the read strobe, which is when inflight_q is set.
      if (inflight_q) begin
         buf_data_d[wr_ptr_q] = mem_rdata;
         buf_last_d[wr_ptr_q] = inflight_last_q;
         wr_ptr_d             = !wr_ptr_q;
      end
      if (pop)
         rd_ptr_d = !rd_ptr_q;

      count_d = count_q + 2'(inflight_q) - 2'(pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= IDLE;
         addr_q          <= '0;
         wrap_mask_q     <= '0;
         mode_q          <= MODE_INCR;
         remaining_q     <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         buf_data_q      <= '{default: '0};
         buf_last_q      <= '{default: 1'b0};
         wr_ptr_q        <= 1'b0;
         rd_ptr_q        <= 1'b0;
         count_q         <= 2'd0;
      end else begin
         state_q         <= state_d;
         addr_q          <= addr_d;
         wrap_mask_q     <= wrap_mask_d;
         mode_q          <= mode_d;
         remaining_q     <= remaining_d;
         inflight_q      <= inflight_d;
         inflight_last_q <= inflight_last_d;
         buf_data_q      <= buf_data_d;
         buf_last_q      <= buf_last_d;
         wr_ptr_q        <= wr_ptr_d;
         rd_ptr_q        <= rd_ptr_d;
         count_q         <= count_d;
      end
   end

   assign mem_en   = issue;
   assign mem_addr = addr_q;
   assign u_valid  = (count_q != 2'd0);
   assign u_data   = buf_data_q[rd_ptr_q];
   assign u_last   = buf_last_q[rd_ptr_q] && u_valid;

endmodule

// File: tb/tb_axi_ram_read_beat_gen.sv
// tb/tb_axi_ram_read_beat_gen.sv - randomized bench for axi_ram_read_beat_gen with a burst-level reference model
module tb_axi_ram_read_beat_gen;
   logic        clk;
   logic        rst;
   logic [31:0] cmd_addr;
   logic [7:0]  cmd_len;
   logic [1:0]  cmd_burst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        mem_en;
   logic [31:0] mem_addr;
   logic [63:0] mem_rdata;
   logic [63:0] u_data;
   logic        u_valid;
   logic        u_last;
   logic        u_ready;

   axi_ram_read_beat_gen #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .LEN_WIDTH(8)) dut (
      .clk(clk), .rst(rst),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_burst(cmd_burst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .u_data(u_data), .u_valid(u_valid), .u_last(u_last), .u_ready(u_ready)
   );

   typedef struct {logic [31:0] addr; logic last;} issue_t;
   typedef struct {logic [63:0] data; logic last;} beat_t;

   issue_t      exp_addr[$];
   beat_t       exp_beat[$];
   int          n_chk = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          outstanding = 0;
   int          last_issue_cyc = 0;
   int          last_accept_cyc = 0;
   int          ready_mode = 0;
   bit [31:0]   read_seq = '0;
   logic        prev_stall = 1'b0;
   logic [63:0] prev_data = '0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // RAM model: one-cycle read latency, data = {read sequence number, address}.
   always @(posedge clk) begin
      if (mem_en) begin
         mem_rdata <= {read_seq, mem_addr};
         read_seq  <= read_seq + 1;
      end
   end

   initial begin
      u_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       u_ready = 1'b1;
            1:       u_ready = 1'($urandom_range(0, 1));
            default: u_ready = 1'b0;
         endcase
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model_addr(input logic [31:0] a, input int len,
                                              input logic [1:0] burst, input int i);
      int unsigned beats;
      int unsigned size;
      logic [31:0] base;
      beats = len + 1;
      size  = beats * 8;
      if (burst == 2'b00) return a;
      if (burst == 2'b10 && (beats == 2 || beats == 4 || beats == 8 || beats == 16)) begin
         base = a - (a % size);
         return base + ((a - base + i * 8) % size);
      end
      return a + i * 8;
   endfunction

   // Scoreboard: address order at issue, data/last order at the output, occupancy and stall stability.
   initial begin
      issue_t e;
      beat_t  b;
      forever begin
         @(negedge clk);
         if (rst) begin
            exp_addr.delete();
            exp_beat.delete();
            outstanding = 0;
            prev_stall  = 1'b0;
         end else begin
            chk("outstanding_le2", 64'(outstanding <= 2), 64'(1));
            if (prev_stall) begin
               chk("stall_valid", 64'(u_valid), 64'(1));
               chk("stall_data", u_data, prev_data);
            end
            if (u_valid && u_ready) begin
               if (exp_beat.size() == 0) begin
                  chk("extra_beat", 64'(exp_beat.size()), 64'(1));
               end else begin
                  b = exp_beat.pop_front();
                  chk("u_data", u_data, b.data);
                  chk("u_last", 64'(u_last), 64'(b.last));
               end
               outstanding--;
            end
            if (mem_en) begin
               if (exp_addr.size() == 0) begin
                  chk("extra_issue", 64'(exp_addr.size()), 64'(1));
               end else begin
                  e = exp_addr.pop_front();
                  chk("mem_addr", 64'(mem_addr), 64'(e.addr));
                  b.data = {read_seq, e.addr};
                  b.last = e.last;
                  exp_beat.push_back(b);
                  if (e.last) last_issue_cyc = cyc;
               end
               outstanding++;
            end
            if (cmd_valid && cmd_ready) begin
               for (int i = 0; i <= int'(cmd_len); i++) begin
                  e.addr = model_addr(cmd_addr, int'(cmd_len), cmd_burst, i);
                  e.last = (i == int'(cmd_len));
                  exp_addr.push_back(e);
               end
               last_accept_cyc = cyc;
            end
            prev_stall = u_valid && !u_ready;
            prev_data  = u_data;
         end
      end
   end

   task automatic send_cmd(input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst);
      bit got;
      got       = 1'b0;
      cmd_addr  = a;
      cmd_len   = len;
      cmd_burst = burst;
      cmd_valid = 1'b1;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (cmd_ready) begin
            got = 1'b1;
            break;
         end
      end
      chk("cmd_accept", 64'(got), 64'(1));
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_drain();
      bit done;
      done = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         if (exp_addr.size() == 0 && exp_beat.size() == 0) begin
            done = 1'b1;
            break;
         end
      end
      chk("drain", 64'(done), 64'(1));
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_addr  = '0;
      cmd_len   = '0;
      cmd_burst = 2'b01;
      @(negedge clk);
      chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_cmd_ready_after", 64'(cmd_ready), 64'(1));
      chk("rst_mem_en", 64'(mem_en), 64'(0));
      chk("rst_mem_addr", 64'(mem_addr), 64'(0));
      chk("rst_u_valid", 64'(u_valid), 64'(0));
      chk("rst_u_last", 64'(u_last), 64'(0));
      chk("rst_u_data", u_data, 64'(0));
      @(posedge clk);
      #1;

      // INCR latency and beat timing with u_ready held high.
      send_cmd(32'h100, 8'd3, 2'b01);
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         if (c == 1) chk("t1_mem_en_cycle1", 64'(mem_en), 64'(1));
         chk("t1_u_valid", 64'(u_valid), 64'(c >= 3 && c <= 6));
         chk("t1_u_last", 64'(u_last), 64'(c == 6));
      end
      @(posedge clk);
      #1;
      wait_drain();

      send_cmd(32'h118, 8'd3, 2'b10);
      wait_drain();
      send_cmd(32'h118, 8'd2, 2'b10);
      wait_drain();
      send_cmd(32'h40, 8'd7, 2'b00);
      wait_drain();
      send_cmd(32'hFFFF_FFF0, 8'd3, 2'b01);
      wait_drain();

      // Long INCR with random backpressure and a held stall.
      ready_mode = 1;
      send_cmd($urandom & 32'hFFFF_FFF8, 8'd15, 2'b01);
      repeat (4) @(posedge clk);
      ready_mode = 2;
      repeat (12) @(posedge clk);
      @(negedge clk);
      chk("stall_buffered", 64'(outstanding), 64'(2));
      chk("stall_mem_en", 64'(mem_en), 64'(0));
      chk("stall_cmd_ready", 64'(cmd_ready), 64'(0));
      ready_mode = 1;
      @(posedge clk);
      #1;
      wait_drain();
      ready_mode = 0;

      // Back-to-back: second accept one cycle after the first burst's final issue.
      send_cmd(32'h200, 8'd0, 2'b01);
      send_cmd(32'h300, 8'd1, 2'b01);
      chk("b2b_gap", 64'(last_accept_cyc - last_issue_cyc), 64'(1));
      wait_drain();

      // Reset mid-burst.
      send_cmd(32'h500, 8'd7, 2'b01);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_u_valid", 64'(u_valid), 64'(0));
      chk("post_rst_mem_en", 64'(mem_en), 64'(0));
      chk("post_rst_cmd_ready", 64'(cmd_ready), 64'(1));
      @(posedge clk);
      #1;
      send_cmd(32'h600, 8'd0, 2'b01);
      wait_drain();

      ready_mode = 1;
      for (int n = 0; n < 8; n++) begin
         send_cmd($urandom, 8'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
         wait_drain();
      end
      ready_mode = 0;

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/axi_ram_read_beat_gen.md
Name: axi_ram_read_beat_gen

Overview:
- Read-channel beat generator sitting directly upstream of the 1-stage pipeline insert, between the RAM read port and the R-path toward the bus.
- Accepts one read burst command (address, length, burst type) and issues one synchronous RAM read per beat.
- Buffers the returned data so downstream backpressure never loses a beat.
- Emits data/valid/last on a valid/ready interface that feeds the pipeline insert's upstream port.

Parameters:
- DATA_WIDTH, 64, width of RAM read data and output beat data (power of 2, ≥8).
- ADDR_WIDTH, 32, byte address width.
- LEN_WIDTH, 8, burst length field width; beats = cmd_len + 1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- cmd_addr  in  ADDR_WIDTH  start byte address of the burst.
- cmd_len  in  LEN_WIDTH  beats minus one.
- cmd_burst  in  2  00=FIXED, 01=INCR, 10=WRAP, 11=reserved (treated as INCR).
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at a rising edge.
- mem_en  out  1  RAM read strobe.
- mem_addr  out  ADDR_WIDTH  RAM byte address for this read.
- mem_rdata  in  DATA_WIDTH  RAM data, valid exactly one cycle after mem_en.
- u_data  out  DATA_WIDTH  beat data.
- u_valid  out  1  beat valid.
- u_last  out  1  final beat of burst (qualified by u_valid).
- u_ready  in  1  downstream accepts beat when u_valid & u_ready.

Behaviour:
- Reset (rst=1 at an edge):
  - State → IDLE; buffer, counters and in-flight flag cleared.
  - Outputs: cmd_ready=0 during the reset cycle and 1 after; mem_en=0, mem_addr=0, u_valid=0, u_last=0, u_data=0.
  - Reset mid-burst discards all buffered and in-flight beats; no partial burst resumes.
- FSM has two states, IDLE and ISSUE.
  - cmd_ready = (state==IDLE).
  - On accept: latch addr/len/burst, set beat counter = cmd_len, state → ISSUE.
- ISSUE: mem_en=1 in a cycle iff (buf_count + inflight − pop) < 2, where pop = u_valid & u_ready this cycle.
  - Each issue decrements the remaining count.
  - On the issue of the final beat, state → IDLE. A new command may be accepted the cycle after, while earlier beats still drain.
- Address generation; STEP = DATA_WIDTH/8:
  - FIXED: every beat uses the start address.
  - INCR: addr += STEP per beat, modulo 2^ADDR_WIDTH (wraps silently at top).
  - WRAP: legal only for beats ∈ {2,4,8,16}. Wrap boundary = beats*STEP, aligned down; when the address reaches the boundary top it returns to the boundary base. With an illegal WRAP length, behave as INCR.
- In-flight tracking: the in-flight flag is set the cycle after mem_en and carries a last tag. On the next edge, mem_rdata and the tag are written into a 2-entry FIFO.
- Output: u_data/u_valid/u_last come from the FIFO head (registered), and are held stable while u_valid & !u_ready.
- Latency: cmd accepted at edge 0 → mem_en high in cycle 1 → data captured at edge 2 → u_valid high in cycle 3.
- Throughput: 1 beat/cycle sustained with u_ready held high.
- Boundaries:
  - The FIFO never overflows: the issue gating above guarantees it.
  - Simultaneous push and pop with count=2 is not reachable.
  - With count=1 and simultaneous push and pop, count stays 1.
  - cmd_len=0 gives a single beat with u_last=1.
  - u_ready low indefinitely: exactly 2 beats buffered, mem_en stays 0 afterward, cmd_ready unaffected once issuing completes.
  - u_last is asserted on exactly one beat per burst.

Test Plan:
- Reset, then INCR addr=0x100, len=3, u_ready=1 → mem_addr 0x100, 0x108, 0x110, 0x118 on consecutive cycles; u_valid cycles 3–6; u_last only on the 4th beat.
- WRAP addr=0x118, len=3 → mem_addr 0x118, 0x100, 0x108, 0x110. Then WRAP with len=2 (3 beats, illegal) → INCR order.
- FIXED addr=0x40, len=7 → all 8 mem_addr = 0x40; 8 beats returned in order with RAM model data = address-derived counter.
- INCR len=15, u_ready toggled pseudo-randomly, held low 10 cycles mid-burst → never more than 2 beats outstanding, no beat lost or duplicated, u_data stable while stalled.
- Back-to-back commands len=0 then len=1 → second cmd_ready handshake one cycle after first burst's final issue; 3 beats total, u_last on beat 1 and beat 3.
- Assert rst for 1 cycle mid-burst of len=7 → u_valid=0 and mem_en=0 next cycle; cmd_ready=1 the cycle after; a new len=0 burst completes normally.
